// File: rtl/aes_sub_bytes_sched_pkg.sv
// aes_sub_bytes_sched_pkg: AES byte/word/state types, scheduler FSM states and a computed FIPS-197 S-box
package aes_sub_bytes_sched_pkg;
  localparam int AES_STATE_BYTES = 16;
  localparam int AES_WORD_BYTES = 4;
  typedef logic [7:0] aes_byte;
  typedef aes_byte [AES_WORD_BYTES-1:0] aes_word;
  typedef aes_byte [AES_STATE_BYTES-1:0] aes_state;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} aes_sub_sched_state_e;
  function automatic aes_byte gf_mul(aes_byte a, aes_byte b);
    aes_byte p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  function automatic aes_byte sbox(aes_byte a);
    aes_byte p, s;
    p = a;
    s = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      s = gf_mul(s, p);
    end
    return s ^ {s[6:0], s[7]} ^ {s[5:0], s[7:6]} ^ {s[4:0], s[7:5]} ^ {s[3:0], s[7:4]} ^ 8'h63;
  endfunction
endpackage

// File: rtl/aes_sub_bytes_sched_if.sv
// aes_sub_bytes_sched_if: state/word request and result bundle for the shared S-box scheduler
interface aes_sub_bytes_sched_if;
  logic st_valid_i, st_ready_o, st_done_o;
  logic ks_valid_i, ks_ready_o, ks_done_o;
  logic [127:0] st_data_i, st_data_o;
  logic [31:0] ks_data_i, ks_data_o;
  logic [15:0] conflict_cnt_o;
  modport slave (
    input st_valid_i, st_data_i, ks_valid_i, ks_data_i,
    output st_ready_o, st_done_o, st_data_o, ks_ready_o, ks_done_o, ks_data_o, conflict_cnt_o
  );
  modport master (
    output st_valid_i, st_data_i, ks_valid_i, ks_data_i,
    input st_ready_o, st_done_o, st_data_o, ks_ready_o, ks_done_o, ks_data_o, conflict_cnt_o
  );
endinterface

// File: rtl/aes_sub_bytes_sched_lut.sv
// aes_sub_byte_lut: single S-box lookup instance
module aes_sub_byte_lut
  import aes_sub_bytes_sched_pkg::*;
(
  input  aes_byte x,
  output aes_byte y
);
  assign y = sbox(x);
endmodule

// File: rtl/aes_sub_bytes_sched.sv
// aes_sub_bytes_sched: shares NUM_SBOX S-box LUTs between state SubBytes and key SubWord; AES_SUB_SCHED_CONFLICT_CNT_EN adds a contention counter
module aes_sub_bytes_sched
  import aes_sub_bytes_sched_pkg::*;
#(
  parameter int NUM_SBOX = 4
) (
  input logic clk_i,
  input logic rst_i,
  aes_sub_bytes_sched_if.slave bus
);
  localparam int KS = AES_STATE_BYTES / NUM_SBOX;
  localparam int KW = (AES_WORD_BYTES + NUM_SBOX - 1) / NUM_SBOX;
  if (NUM_SBOX != 1 && NUM_SBOX != 2 && NUM_SBOX != 4) begin : g_bad_num_sbox
    $error("NUM_SBOX must be 1, 2 or 4");
  end
  aes_sub_sched_state_e fsm;
  aes_state work, work_nx;
  aes_byte [NUM_SBOX-1:0] lut_x, lut_y;
  logic [3:0] cnt;
  logic op_ks, rr_ks, idle, gnt_ks, gnt_st, last;
  assign idle = fsm == IDLE;
  assign gnt_ks = bus.ks_valid_i && (!bus.st_valid_i || rr_ks);
  assign gnt_st = bus.st_valid_i && !gnt_ks;
  assign bus.st_ready_o = idle && gnt_st;
  assign bus.ks_ready_o = idle && gnt_ks;
  assign bus.st_done_o = fsm == DONE && !op_ks;
  assign bus.ks_done_o = fsm == DONE && op_ks;
  assign last = cnt == (op_ks ? 4'(KW - 1) : 4'(KS - 1));
  for (genvar i = 0; i < NUM_SBOX; i++) begin : g_lut
    assign lut_x[i] = work[4'(int'(cnt) * NUM_SBOX + i)];
    aes_sub_byte_lut u_lut (.x(lut_x[i]), .y(lut_y[i]));
  end
  // working register with the current chunk replaced by its substituted bytes
  always_comb begin
    work_nx = work;
    for (int i = 0; i < NUM_SBOX; i++) work_nx[4'(int'(cnt) * NUM_SBOX + i)] = lut_y[i];
  end
  // arbitration, chunk sequencing and result capture
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm <= IDLE;
      work <= '0;
      cnt <= '0;
      op_ks <= 1'b0;
      rr_ks <= 1'b1;
      bus.st_data_o <= '0;
      bus.ks_data_o <= '0;
    end else if (fsm == IDLE) begin
      if (bus.st_valid_i || bus.ks_valid_i) begin
        fsm <= BUSY;
        cnt <= '0;
        op_ks <= gnt_ks;
        rr_ks <= gnt_st;
        work <= gnt_ks ? {96'h0, bus.ks_data_i} : bus.st_data_i;
      end
    end else if (fsm == BUSY) begin
      work <= work_nx;
      cnt <= cnt + 4'd1;
      if (last) begin
        fsm <= DONE;
        if (op_ks) bus.ks_data_o <= work_nx[3:0];
        else bus.st_data_o <= work_nx;
      end
    end else begin
      fsm <= IDLE;
    end
  end
`ifdef AES_SUB_SCHED_CONFLICT_CNT_EN
  logic [15:0] ccnt;
  logic hit;
  assign hit = idle ? bus.st_valid_i && bus.ks_valid_i : bus.st_valid_i || bus.ks_valid_i;
  assign bus.conflict_cnt_o = ccnt;
  // saturating count of cycles where a requester is kept waiting
  always_ff @(posedge clk_i) begin
    if (rst_i) ccnt <= '0;
    else if (hit && ccnt != 16'hffff) ccnt <= ccnt + 16'd1;
  end
`else
  assign bus.conflict_cnt_o = 16'h0000;
`endif
endmodule

// File: tb/tb_aes_sub_bytes_sched.sv
// tb_aes_sub_bytes_sched: directed vectors against a transaction-level model for NUM_SBOX=4 and NUM_SBOX=1
module tb_aes_sub_bytes_sched;
  localparam logic [0:255][7:0] SBOX = 2048'h637c777bf26b6fc53001672bfed7ab76_ca82c97dfa5947f0add4a2af9ca472c0_b7fd9326363ff7cc34a5e5f171d83115_04c723c31896059a071280e2eb27b275_09832c1a1b6e5aa0523bd6b329e32f84_53d100ed20fcb15b6acbbe394a4c58cf_d0efaafb434d338545f9027f503c9fa8_51a3408f929d38f5bcb6da2110fff3d2_cd0c13ec5f974417c4a77e3d645d1973_60814fdc222a908846eeb814de5e0bdb_e0323a0a4906245cc2d3ac629195e479_e7c8376d8dd54ea96c56f4ea657aae08_ba78252e1ca6b4c6e8dd741f4bbd8b8a_703eb5664803f60e613557b986c11d9e_e1f8981169d98e949b1e87e9ce5528df_8ca1890dbfe6426841992d0fb054bb16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  aes_sub_bytes_sched_if if4 ();
  aes_sub_bytes_sched_if if1 ();
  aes_sub_bytes_sched #(.NUM_SBOX(4)) u4 (.clk_i(clk), .rst_i(rst), .bus(if4));
  aes_sub_bytes_sched #(.NUM_SBOX(1)) u1 (.clk_i(clk), .rst_i(rst), .bus(if1));
  logic st_v[2], ks_v[2], st_rdy[2], ks_rdy[2], st_dn[2], ks_dn[2];
  logic [127:0] st_d[2], st_q[2];
  logic [31:0] ks_d[2], ks_q[2];
  logic [15:0] cc[2];
  assign if4.st_valid_i = st_v[0];
  assign if4.st_data_i = st_d[0];
  assign if4.ks_valid_i = ks_v[0];
  assign if4.ks_data_i = ks_d[0];
  assign if1.st_valid_i = st_v[1];
  assign if1.st_data_i = st_d[1];
  assign if1.ks_valid_i = ks_v[1];
  assign if1.ks_data_i = ks_d[1];
  assign st_rdy[0] = if4.st_ready_o;
  assign ks_rdy[0] = if4.ks_ready_o;
  assign st_dn[0] = if4.st_done_o;
  assign ks_dn[0] = if4.ks_done_o;
  assign st_q[0] = if4.st_data_o;
  assign ks_q[0] = if4.ks_data_o;
  assign cc[0] = if4.conflict_cnt_o;
  assign st_rdy[1] = if1.st_ready_o;
  assign ks_rdy[1] = if1.ks_ready_o;
  assign st_dn[1] = if1.st_done_o;
  assign ks_dn[1] = if1.ks_done_o;
  assign st_q[1] = if1.st_data_o;
  assign ks_q[1] = if1.ks_data_o;
  assign cc[1] = if1.conflict_cnt_o;
  int n_chk = 0;
  int n_pass = 0;
  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  function automatic logic [127:0] sub(logic [127:0] x, int nb);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < nb; i++) r[8*i+:8] = SBOX[x[8*i+:8]];
    return r;
  endfunction
  int free_in[2], done_in[2];
  logic ok[2], pk[2], pref[2];
  logic [127:0] pres[2], e_st[2];
  logic [31:0] e_ks[2];
  logic [15:0] e_cc[2];
  // model: per-cycle expected outputs from occupancy, round-robin preference and pending result
  always @(negedge clk) begin
    int n, k;
    bit idle, er_st, er_ks, ed;
    string nm;
    for (int d = 0; d < 2; d++) begin
      n = d ? 1 : 4;
      nm = d ? "n1" : "n4";
      idle = free_in[d] == 0;
      er_st = idle && st_v[d] && !(ks_v[d] && pref[d]);
      er_ks = idle && ks_v[d] && (!st_v[d] || pref[d]);
      ed = done_in[d] == 0;
      if (ok[d]) begin
        if (ed && !pk[d]) e_st[d] = pres[d];
        if (ed && pk[d]) e_ks[d] = pres[d][31:0];
        chk({nm, " st_ready"}, 128'(st_rdy[d]), 128'(er_st));
        chk({nm, " ks_ready"}, 128'(ks_rdy[d]), 128'(er_ks));
        chk({nm, " st_done"}, 128'(st_dn[d]), 128'(ed && !pk[d]));
        chk({nm, " ks_done"}, 128'(ks_dn[d]), 128'(ed && pk[d]));
        chk({nm, " st_data"}, st_q[d], e_st[d]);
        chk({nm, " ks_data"}, 128'(ks_q[d]), 128'(e_ks[d]));
        chk({nm, " conflict"}, 128'(cc[d]), 128'(e_cc[d]));
      end
      if (rst) begin
        ok[d] = 1'b1;
        free_in[d] = 0;
        done_in[d] = -1;
        pref[d] = 1'b1;
        pk[d] = 1'b0;
        e_st[d] = '0;
        e_ks[d] = '0;
        e_cc[d] = '0;
      end else begin
`ifdef AES_SUB_SCHED_CONFLICT_CNT_EN
        if ((idle ? st_v[d] && ks_v[d] : st_v[d] || ks_v[d]) && e_cc[d] != 16'hffff) e_cc[d] = e_cc[d] + 16'd1;
`endif
        if (done_in[d] >= 0) done_in[d]--;
        if (free_in[d] > 0) free_in[d]--;
        if (er_st || er_ks) begin
          k = er_ks ? (4 + n - 1) / n : 16 / n;
          pk[d] = er_ks;
          pref[d] = er_st;
          pres[d] = er_ks ? sub({96'h0, ks_d[d]}, 4) : sub(st_d[d], 16);
          done_in[d] = k;
          free_in[d] = k + 1;
        end
      end
    end
  end
  task automatic run_op(int d, bit ks, logic [127:0] data, output int wt, output int lat);
    @(posedge clk);
    #1;
    if (ks) begin
      ks_v[d] = 1'b1;
      ks_d[d] = data[31:0];
    end else begin
      st_v[d] = 1'b1;
      st_d[d] = data;
    end
    wt = 0;
    @(negedge clk);
    while (!(ks ? ks_rdy[d] : st_rdy[d]) && wt < 100) begin
      wt++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    if (ks) ks_v[d] = 1'b0;
    else st_v[d] = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(ks ? ks_dn[d] : st_dn[d]) && lat < 100);
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask
  initial begin
    #300000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end
  initial begin
    int wa, la, wb, lb;
    logic [31:0] w;
    st_v = '{1'b0, 1'b0};
    ks_v = '{1'b0, 1'b0};
    st_d = '{128'h0, 128'h0};
    ks_d = '{32'h0, 32'h0};
    ok = '{1'b0, 1'b0};
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset st_data", st_q[0], 128'h0);
    chk("reset ready", 128'({st_rdy[0], ks_rdy[0], st_dn[0], ks_dn[0]}), 128'h0);
    run_op(0, 1'b0, 128'h0, wa, la);
    chk("t1 wait", 128'(wa), 128'd0);
    chk("t1 latency", 128'(la), 128'd5);
    chk("t1 data", st_q[0], {16{8'h63}});
    run_op(0, 1'b1, 128'hcf4f3c09, wa, la);
    chk("t2 latency", 128'(la), 128'd2);
    chk("t2 data", 128'(ks_q[0]), 128'h8a84eb01);
    chk("t2 st hold", st_q[0], {16{8'h63}});
    do_reset();
    fork
      run_op(0, 1'b1, 128'h00530053, wa, la);
      run_op(0, 1'b0, {16{8'hff}}, wb, lb);
    join
    chk("t3 ks wait", 128'(wa), 128'd0);
    chk("t3 ks latency", 128'(la), 128'd2);
    chk("t3 st wait", 128'(wb), 128'd3);
    chk("t3 st latency", 128'(lb), 128'd5);
    chk("t3 ks data", 128'(ks_q[0]), 128'h63ed63ed);
    chk("t3 st data", st_q[0], {16{8'h16}});
`ifdef AES_SUB_SCHED_CONFLICT_CNT_EN
    chk("t3 conflict", 128'(cc[0]), 128'd3);
`else
    chk("t3 conflict", 128'(cc[0]), 128'd0);
`endif
    run_op(0, 1'b0, {16{8'h01}}, wa, la);
    chk("t4 first data", st_q[0], {16{8'h7c}});
    run_op(0, 1'b0, {16{8'h10}}, wb, lb);
    chk("t4 second wait", 128'(wb), 128'd0);
    chk("t4 second latency", 128'(lb), 128'd5);
    chk("t4 second data", st_q[0], {16{8'hca}});
    @(posedge clk);
    #1;
    st_v[0] = 1'b1;
    st_d[0] = {16{8'h20}};
    @(negedge clk);
    chk("t5 ready", 128'(st_rdy[0]), 128'd1);
    @(posedge clk);
    #1 st_v[0] = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    st_v[0] = 1'b1;
    st_d[0] = {16{8'h30}};
    @(negedge clk);
    chk("t5 st_data cleared", st_q[0], 128'h0);
    chk("t5 ks_data cleared", 128'(ks_q[0]), 128'h0);
    chk("t5 no done", 128'(st_dn[0]), 128'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t5 ready after reset", 128'(st_rdy[0]), 128'd1);
    @(posedge clk);
    #1 st_v[0] = 1'b0;
    la = 0;
    do begin
      @(negedge clk);
      la++;
    end while (!st_dn[0] && la < 100);
    chk("t5 latency", 128'(la), 128'd5);
    chk("t5 data", st_q[0], {16{8'h04}});
    for (int j = 0; j < 64; j++) begin
      w = {8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)};
      run_op(1, 1'b1, 128'(w), wa, la);
      chk($sformatf("t6 latency %0d", j), 128'(la), 128'd5);
      chk($sformatf("t6 data %0d", j), 128'(ks_q[1]), 128'({SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]}));
    end
    chk("t6 sbox 00", 128'(SBOX[8'h00]), 128'(ks_q[1][7:0] == 8'h00 ? 8'h00 : 8'h63));
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
